// File: rtl/lookupflow_pkg.sv
// Shared definitions for the flow-table lookup engine: header tuple layout,
// table entry type and the fixed reset-time flow table.
package lookupflow_pkg;

    localparam int TUPLE_W      = 243;
    localparam int IN_PORT_LSB  = 239;
    localparam int IN_PORT_W    = 4;
    localparam int DL_DST_LSB   = 191;
    localparam int DL_SRC_LSB   = 143;
    localparam int DL_TYPE_LSB  = 127;
    localparam int VLAN_ID_LSB  = 115;
    localparam int VLAN_PCP_LSB = 112;
    localparam int NW_SRC_LSB   = 80;
    localparam int NW_DST_LSB   = 48;
    localparam int NW_DST_W     = 32;
    localparam int NW_PROTO_LSB = 40;
    localparam int NW_TOS_LSB   = 32;
    localparam int TP_SRC_LSB   = 16;
    localparam int TP_DST_LSB   = 0;

    localparam int TABLE_DEPTH  = 8;
    localparam int PORT_W       = 4;

    typedef struct packed {
        logic                valid;
        logic [NW_DST_W-1:0] key;
        logic [NW_DST_W-1:0] mask;
        logic [PORT_W-1:0]   ports;
    } entry_t;

    localparam entry_t [TABLE_DEPTH-1:0] DEFAULT_TABLE = '{
        7: '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
        6: '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
        5: '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
        4: '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
        3: '{1'b1, 32'h0A00_0004, 32'hFFFF_FFFF, 4'b1000},
        2: '{1'b1, 32'h0A00_0003, 32'hFFFF_FFFF, 4'b0100},
        1: '{1'b1, 32'h0A00_0002, 32'hFFFF_FFFF, 4'b0010},
        0: '{1'b1, 32'h0A00_0001, 32'hFFFF_FFFF, 4'b0001}
    };

endpackage

// File: rtl/lookupflow_entry_cmp.sv
// Masked compare of the lookup key against a single flow-table entry.
module lookupflow_entry_cmp
    import lookupflow_pkg::*;
(
    input  logic                ent_valid,
    input  logic [NW_DST_W-1:0] ent_key,
    input  logic [NW_DST_W-1:0] ent_mask,
    input  logic [NW_DST_W-1:0] key,
    output logic                hit
);

    assign hit = ent_valid && (((key ^ ent_key) & ent_mask) == '0);

endmodule

// File: rtl/lookupflow.sv
// Three-register lookup pipeline: capture key, parallel compare, priority select.
// Optional LOOKUPFLOW_FLOOD_ON_MISS_EN floods a miss to all ports except in_port.
module lookupflow
    import lookupflow_pkg::*;
#(
    parameter int NPORT = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               of_lookup_req,
    input  logic [TUPLE_W-1:0] of_lookup_data,
    output logic               of_lookup_ack,
    output logic               of_lookup_err,
    output logic [PORT_W-1:0]  of_lookup_fwd_port
);

    localparam logic [PORT_W-1:0] PORTMASK = PORT_W'((1 << NPORT) - 1);

    logic [1:0]             vld_pipe;
    logic [NW_DST_W-1:0]    key_q;
    logic [TABLE_DEPTH-1:0] hit;
    logic [TABLE_DEPTH-1:0] hit_q;
    logic                   any_hit;
    logic [PORT_W-1:0]      sel_ports;
    logic [PORT_W-1:0]      miss_ports;
    logic                   miss_err;

`ifdef LOOKUPFLOW_FLOOD_ON_MISS_EN
    logic [IN_PORT_W-1:0] in_port_q;
    logic [IN_PORT_W-1:0] in_port_q2;
    logic                 unused_fields;
    assign unused_fields = ^{of_lookup_data[238:80], of_lookup_data[47:0]};
`else
    logic unused_fields;
    assign unused_fields = ^{of_lookup_data[242:80], of_lookup_data[47:0]};
`endif

    // Stage 1: capture key only when a request is presented
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            vld_pipe[0] <= 1'b0;
            key_q       <= '0;
        end else begin
            vld_pipe[0] <= of_lookup_req;
            if (of_lookup_req) key_q <= of_lookup_data[NW_DST_LSB +: NW_DST_W];
        end
    end

    for (genvar i = 0; i < TABLE_DEPTH; i++) begin : g_cmp
        lookupflow_entry_cmp u_cmp (
            .ent_valid (DEFAULT_TABLE[i].valid),
            .ent_key   (DEFAULT_TABLE[i].key),
            .ent_mask  (DEFAULT_TABLE[i].mask),
            .key       (key_q),
            .hit       (hit[i])
        );
    end

    // Stage 2: register per-entry hit bits
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            vld_pipe[1] <= 1'b0;
            hit_q       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            hit_q       <= hit;
        end
    end

`ifdef LOOKUPFLOW_FLOOD_ON_MISS_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            in_port_q  <= '0;
            in_port_q2 <= '0;
        end else begin
            if (of_lookup_req) in_port_q <= of_lookup_data[IN_PORT_LSB +: IN_PORT_W];
            in_port_q2 <= in_port_q;
        end
    end
    // Out-of-range in_port shifts outside the mask, so it floods everywhere
    assign miss_ports = PORTMASK & ~(PORT_W'(1) << in_port_q2);
    assign miss_err   = 1'b0;
`else
    assign miss_ports = '0;
    assign miss_err   = 1'b1;
`endif

    // Walk from the top so the lowest hitting index is the one left standing
    always_comb begin
        any_hit   = 1'b0;
        sel_ports = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                any_hit   = 1'b1;
                sel_ports = DEFAULT_TABLE[i].ports;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            of_lookup_ack      <= 1'b0;
            of_lookup_err      <= 1'b0;
            of_lookup_fwd_port <= '0;
        end else begin
            of_lookup_ack <= vld_pipe[1];
            of_lookup_err <= vld_pipe[1] && !any_hit && miss_err;
            if (vld_pipe[1])
                of_lookup_fwd_port <= any_hit ? (sel_ports & PORTMASK) : miss_ports;
        end
    end

endmodule

// File: tb/tb_lookupflow.sv
// Directed bench for lookupflow: a 4-port and a 2-port instance share stimulus.
// Expected miss results follow LOOKUPFLOW_FLOOD_ON_MISS_EN when it is defined.
module tb_lookupflow;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         of_lookup_req = 1'b0;
    logic [242:0] of_lookup_data = '0;
    logic         ack4, err4, ack2, err2;
    logic [3:0]   fwd4, fwd2;

    int checks = 0;
    int errors = 0;

    always #4 sys_clk = ~sys_clk;

    lookupflow #(.NPORT(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
        .of_lookup_ack(ack4), .of_lookup_err(err4), .of_lookup_fwd_port(fwd4)
    );

    lookupflow #(.NPORT(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
        .of_lookup_ack(ack2), .of_lookup_err(err2), .of_lookup_fwd_port(fwd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ip(input int d);
        return {8'd10, 8'd0, 8'd0, 8'(d)};
    endfunction

    // Non-key fields are all ones to show they do not influence the result
    task automatic drive(input logic [31:0] dst, input logic [3:0] inport);
        logic [242:0] d;
        d = '1;
        d[79:48]   = dst;
        d[242:239] = inport;
        of_lookup_data = d;
        of_lookup_req  = 1'b1;
    endtask

    task automatic check_res(input string tag, input logic e, input logic [3:0] f4,
                             input logic [3:0] f2);
        chk({tag, " ack4"}, 32'(ack4), 32'd1);
        chk({tag, " err4"}, 32'(err4), 32'(e));
        chk({tag, " fwd4"}, 32'(fwd4), 32'(f4));
        chk({tag, " ack2"}, 32'(ack2), 32'd1);
        chk({tag, " err2"}, 32'(err2), 32'(e));
        chk({tag, " fwd2"}, 32'(fwd2), 32'(f2));
    endtask

    task automatic lookup(input string tag, input int d, input logic [3:0] inport,
                          input logic e, input logic [3:0] f4, input logic [3:0] f2);
        drive(ip(d), inport);
        @(negedge sys_clk);
        of_lookup_req = 1'b0;
        chk({tag, " no ack +0"}, 32'(ack4), 32'd0);
        @(negedge sys_clk);
        chk({tag, " no ack +1"}, 32'(ack4), 32'd0);
        @(negedge sys_clk);
        check_res(tag, e, f4, f2);
        @(negedge sys_clk);
        chk({tag, " ack drop"}, 32'(ack4), 32'd0);
        chk({tag, " err drop"}, 32'(err4), 32'd0);
        chk({tag, " fwd hold"}, 32'(fwd4), 32'(f4));
    endtask

`ifdef LOOKUPFLOW_FLOOD_ON_MISS_EN
    localparam logic       MISS_ERR = 1'b0;
    localparam logic [3:0] MISS4_P0 = 4'b1110;
    localparam logic [3:0] MISS2_P0 = 4'b0010;
`else
    localparam logic       MISS_ERR = 1'b1;
    localparam logic [3:0] MISS4_P0 = 4'b0000;
    localparam logic [3:0] MISS2_P0 = 4'b0000;
`endif

    initial begin
        repeat (2) @(negedge sys_clk);
        chk("rst ack", 32'(ack4), 32'd0);
        chk("rst err", 32'(err4), 32'd0);
        chk("rst fwd", 32'(fwd4), 32'd0);
        sys_rst = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            chk("post-rst ack", 32'({ack4, ack2}), 32'd0);
            chk("post-rst fwd", 32'(fwd4), 32'd0);
        end

        lookup("hit .1", 1, 4'd0, 1'b0, 4'b0001, 4'b0001);
        lookup("hit .2", 2, 4'd1, 1'b0, 4'b0010, 4'b0010);
        lookup("hit .3", 3, 4'd0, 1'b0, 4'b0100, 4'b0000);
        lookup("hit .4", 4, 4'd0, 1'b0, 4'b1000, 4'b0000);
        lookup("miss .5", 5, 4'd0, MISS_ERR, MISS4_P0, MISS2_P0);
        lookup("miss .6", 6, 4'd0, MISS_ERR, MISS4_P0, MISS2_P0);

        // Back-to-back: .2, .9 (miss, in_port 0), .4
        drive(ip(2), 4'd0);
        @(negedge sys_clk);
        drive(ip(9), 4'd0);
        @(negedge sys_clk);
        drive(ip(4), 4'd0);
        @(negedge sys_clk);
        of_lookup_req = 1'b0;
        check_res("b2b .2", 1'b0, 4'b0010, 4'b0010);
        @(negedge sys_clk);
        check_res("b2b .9", MISS_ERR, MISS4_P0, MISS2_P0);
        @(negedge sys_clk);
        check_res("b2b .4", 1'b0, 4'b1000, 4'b0000);
        @(negedge sys_clk);
        chk("b2b ack end", 32'(ack4), 32'd0);

        // Reset one cycle after a request: output drops at once, lookup discarded
        drive(ip(1), 4'd0);
        @(negedge sys_clk);
        of_lookup_req = 1'b0;
        #1 sys_rst = 1'b0;
        #1;
        chk("async rst fwd", 32'(fwd4), 32'd0);
        chk("async rst ack", 32'(ack4), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            chk("flushed ack", 32'({ack4, ack2}), 32'd0);
            chk("flushed fwd", 32'(fwd4), 32'd0);
        end

        lookup("after rst .3", 3, 4'd0, 1'b0, 4'b0100, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
